key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Debounces one push-button/switch level that a two-flop synchronizer stage upstream has already synchronized to Clock.
- Outputs a clean debounced level plus single-cycle press and release pulses for the Kabeta I/O and interrupt logic.
- One instance per key.
- Purely synchronous to Clock, except for the asynchronous reset.

Parameters:
- CNT_WIDTH, 20, width of the stability counter; requires STABLE_CYCLES <= 2^CNT_WIDTH-1.
- STABLE_CYCLES, 500000, number of consecutive extra samples the new level must hold before it is accepted; minimum 1.
- ACTIVE_LEVEL, 1'b0, raw KeyIn value that means "pressed"; buttons are active-low by default.
- REPEAT_DELAY, 25000000, auto-repeat first delay in cycles; used only with the optional feature.
- REPEAT_PERIOD, 5000000, auto-repeat interval in cycles; used only with the optional feature.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset; asserted on negedge, released synchronously by upstream logic.
- KeyIn  input  1  synchronized raw key level.
- KeyLevel  output  1  debounced level; 1 = pressed, independent of ACTIVE_LEVEL.
- KeyPress  output  1  one-cycle pulse on accepted press.
- KeyRelease  output  1  one-cycle pulse on accepted release.

Behaviour:
- Normalisation: Pressed = (KeyIn == ACTIVE_LEVEL). All logic below uses Pressed.
- Reset (Reset low, asynchronous):
  - state = RELEASED, Count = 0.
  - KeyLevel = 0, KeyPress = 0, KeyRelease = 0.
  - All outputs are registered.
- State machine, 4 states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: Pressed=1 -> PRESS_WAIT with Count=1; otherwise stay, Count=0.
  - PRESS_WAIT:
    - Pressed=0 -> RELEASED, Count=0 (glitch rejected, no pulse).
    - Pressed=1 and Count==STABLE_CYCLES -> PRESSED; KeyLevel<=1, KeyPress<=1 for one cycle.
    - Otherwise Count<=Count+1.
  - PRESSED: Pressed=0 -> RELEASE_WAIT with Count=1; otherwise stay.
  - RELEASE_WAIT: mirror of PRESS_WAIT.
    - Pressed=1 -> PRESSED, no pulse.
    - Pressed=0 and Count==STABLE_CYCLES -> RELEASED; KeyLevel<=0, KeyRelease<=1 for one cycle.
- Latency:
  - Take the first edge sampling the new level as edge 0.
  - KeyLevel changes, and the pulse asserts, immediately after edge STABLE_CYCLES, i.e. STABLE_CYCLES+1 consecutive samples.
- Pulses:
  - KeyPress and KeyRelease are never high in the same cycle.
  - Each is high for exactly one cycle per accepted transition.
- Counter:
  - Never wraps. It is compared for equality and cleared on every state exit.
  - Unused state encodings recover to RELEASED with outputs 0.
- Reset mid-debounce: the pending transition is discarded, no pulse is produced, and the block returns to the reset values above.
- Pulse cleared by reset: a pulse in flight when Reset asserts is cleared immediately.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - While in PRESSED, a repeat counter runs.
  - KeyPress pulses again REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles while still PRESSED.
  - The repeat counter is cleared on leaving PRESSED or on reset.
  - RELEASE_WAIT freezes the repeat counter. A bounce back to PRESSED resumes the count without resetting it.
- Undefined:
  - No repeat counter logic.
  - KeyPress pulses only once per accepted press.
  - REPEAT_* parameters are ignored.

Decomposition:
- Shared package kabeta_io_pkg holds:
  - 2-bit state encodings KEY_RELEASED=2'd0, KEY_PRESS_WAIT=2'd1, KEY_PRESSED=2'd2, KEY_RELEASE_WAIT=2'd3.
  - Default debounce constants.
- One natural sub-module: key_repeat_timer (repeat counter plus pulse generation), instantiated only under KEY_DEBOUNCE_AUTO_REPEAT_EN.
- The FSM and stability counter stay in key_debouncer.

Test Plan (STABLE_CYCLES=4, ACTIVE_LEVEL=0, CNT_WIDTH=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset check: Reset low with KeyIn toggling -> KeyLevel=KeyPress=KeyRelease=0 throughout; after release with KeyIn=1 the outputs stay 0.
- Clean press: KeyIn 1->0 held -> KeyLevel=1 and KeyPress=1 after edge 4 (5th sample); KeyPress low the next cycle; no KeyRelease.
- Bounce rejection: KeyIn=0 for 3 cycles, 1 for 1 cycle, 0 held -> no pulse until 5 consecutive low samples after the bounce; exactly one KeyPress.
- Release: from PRESSED, KeyIn 0->1 held -> KeyLevel=0 and KeyRelease=1 for one cycle after the 5th high sample; a short high glitch of 2 cycles produces nothing.
- Reset mid-operation: Reset low during PRESS_WAIT at Count=3 -> outputs 0, no KeyPress after Reset releases unless 5 fresh low samples occur.
- Auto-repeat (macro defined): hold press -> KeyPress at acceptance, +10 cycles, then every 3 cycles; releasing stops the pulses; macro undefined -> single KeyPress only.

Source files
------------

// File: rtl/kabeta_io_pkg.sv
// Shared Kabeta I/O definitions: key debouncer state encodings and default
// debounce / auto-repeat constants.
package kabeta_io_pkg;

    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int   DEF_CNT_WIDTH     = 20;
    localparam int   DEF_STABLE_CYCLES = 500000;
    localparam logic DEF_ACTIVE_LEVEL  = 1'b0;
    localparam int   DEF_REPEAT_DELAY  = 25000000;
    localparam int   DEF_REPEAT_PERIOD = 5000000;

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer for one debounced key. A down-counter armed with the
// first-repeat delay; each time it reaches zero while the key is held it
// requests a press pulse and reloads with the repeat period. While the key
// is bouncing towards release the count is frozen, otherwise it re-arms.
module key_repeat_timer import kabeta_io_pkg::*; #(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic hold,
    output logic fire
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rem_q, rem_d;

    // Terminal-count decode and reload of the remaining-cycles counter.
    always_comb begin
        rem_d = rem_q;
        fire  = 1'b0;
        if (run) begin
            if (rem_q == '0) begin
                fire  = 1'b1;
                rem_d = RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                rem_d = rem_q - RPT_W'(1);
            end
        end else if (!hold) begin
            rem_d = RPT_W'(REPEAT_DELAY - 1);
        end
    end

    // Remaining-cycles register, re-armed to the first delay on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= RPT_W'(REPEAT_DELAY - 1);
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Single-key debouncer: registered debounced level plus one-cycle press and
// release pulses. A new level is accepted after STABLE_CYCLES+1 consecutive
// samples. Optional auto-repeat of the press pulse is built when
// KEY_DEBOUNCE_AUTO_REPEAT_EN is defined.
//
// state            | meaning
// -----------------+-----------------------------------------------
// KEY_RELEASED     | key settled released, KeyLevel = 0
// KEY_PRESS_WAIT   | pressed level seen, counting stable samples
// KEY_PRESSED      | key settled pressed, KeyLevel = 1
// KEY_RELEASE_WAIT | released level seen, counting stable samples
module key_debouncer import kabeta_io_pkg::*; #(
    parameter int   CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic ACTIVE_LEVEL  = DEF_ACTIVE_LEVEL,
    parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyIn,
    output logic KeyLevel,
    output logic KeyPress,
    output logic KeyRelease
);

    localparam logic [CNT_WIDTH-1:0] CNT_TC = CNT_WIDTH'(STABLE_CYCLES);

    key_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 pressed;
    logic                 rpt_fire;

    assign pressed = (KeyIn == ACTIVE_LEVEL);

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    key_repeat_timer #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .clk   (Clock),
        .rst_n (Reset),
        .run   (state_q == KEY_PRESSED),
        .hold  (state_q == KEY_RELEASE_WAIT),
        .fire  (rpt_fire)
    );
`else
    // Repeat parameters have no function without auto-repeat; keep them referenced.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign rpt_fire       = 1'b0;
`endif

    // Next-state, stability counter and pulse decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            KEY_RELEASED: begin
                level_d = 1'b0;
                if (pressed) begin
                    state_d = KEY_PRESS_WAIT;
                    count_d = CNT_WIDTH'(1);
                end else begin
                    count_d = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = KEY_RELEASED;
                    count_d = '0;
                end else if (count_q == CNT_TC) begin
                    state_d = KEY_PRESSED;
                    count_d = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
            KEY_PRESSED: begin
                level_d = 1'b1;
                press_d = rpt_fire;
                if (!pressed) begin
                    state_d = KEY_RELEASE_WAIT;
                    count_d = CNT_WIDTH'(1);
                end else begin
                    count_d = '0;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = KEY_PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_TC) begin
                    state_d   = KEY_RELEASED;
                    count_d   = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = KEY_RELEASED;
                count_d = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears any pulse in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= KEY_RELEASED;
            count_q   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign KeyLevel   = level_q;
    assign KeyPress   = press_q;
    assign KeyRelease = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4, active-low key,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow the build's
// KEY_DEBOUNCE_AUTO_REPEAT_EN setting.
module tb_key_debouncer;

    logic clk;
    logic rst_n;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;

    int checks;
    int errors;

    key_debouncer #(
        .CNT_WIDTH     (4),
        .STABLE_CYCLES (4),
        .ACTIVE_LEVEL  (1'b0),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .KeyIn      (key_in),
        .KeyLevel   (key_level),
        .KeyPress   (key_press),
        .KeyRelease (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_released(input int n);
        key_in = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            checks++;
            if ({key_level, key_press, key_release} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc%0d outputs=%b expected 000", i,
                         {key_level, key_press, key_release});
            end
        end
        rst_n  = 1'b1;
        key_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({key_level, key_press, key_release} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release cyc%0d outputs=%b expected 000", i,
                         {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        key_in = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            logic exp_level;
            logic exp_press;
            step();
            exp_level = (i >= 4);
            exp_press = (i == 4);
            checks++;
            if (key_level !== exp_level || key_press !== exp_press || key_release !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge%0d lvl/prs/rel=%b%b%b expected %b%b0", i,
                         key_level, key_press, key_release, exp_level, exp_press);
            end
        end
    endtask

    task automatic test_release();
        // short high glitch of two samples from PRESSED
        key_in = 1'b1;
        step();
        step();
        key_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (key_level !== 1'b1 || key_release !== 1'b0) begin
                errors++;
                $display("FAIL release_glitch cyc%0d lvl=%b rel=%b expected 1 0", i,
                         key_level, key_release);
            end
        end
        key_in = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            logic exp_level;
            logic exp_rel;
            step();
            exp_level = (i < 4);
            exp_rel   = (i == 4);
            checks++;
            if (key_level !== exp_level || key_release !== exp_rel || key_press !== 1'b0) begin
                errors++;
                $display("FAIL release edge%0d lvl/prs/rel=%b%b%b expected %b0%b", i,
                         key_level, key_press, key_release, exp_level, exp_rel);
            end
        end
    endtask

    task automatic test_bounce();
        int n_press;
        int at_idx;
        n_press = 0;
        at_idx  = -1;
        idle_released(3);
        key_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (key_press === 1'b1) n_press++;
        end
        key_in = 1'b1;
        step();
        if (key_press === 1'b1) n_press++;
        key_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (key_press === 1'b1) begin
                n_press++;
                at_idx = i;
            end
        end
        checks++;
        if (n_press !== 1) begin
            errors++;
            $display("FAIL bounce_count presses=%0d expected 1", n_press);
        end
        checks++;
        if (at_idx !== 4) begin
            errors++;
            $display("FAIL bounce_latency press_at=%0d expected 4", at_idx);
        end
        idle_released(7);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle lvl=%b expected 0", key_level);
        end
    endtask

    task automatic test_reset_mid();
        idle_released(2);
        key_in = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        step();
        step();
        checks++;
        if ({key_level, key_press, key_release} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_hold outputs=%b expected 000",
                     {key_level, key_press, key_release});
        end
        rst_n = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            logic exp_press;
            step();
            exp_press = (i == 4);
            checks++;
            if (key_press !== exp_press || key_level !== (i >= 4)) begin
                errors++;
                $display("FAIL reset_mid_fresh edge%0d prs=%b lvl=%b expected %b %b", i,
                         key_press, key_level, exp_press, (i >= 4));
            end
        end
        idle_released(7);
    endtask

    task automatic test_pulse_reset();
        key_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (key_press !== 1'b1) begin
            errors++;
            $display("FAIL pulse_reset_pre prs=%b expected 1", key_press);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press} !== 2'b00) begin
            errors++;
            $display("FAIL pulse_reset_async lvl/prs=%b expected 00", {key_level, key_press});
        end
        step();
        rst_n  = 1'b1;
        key_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({key_level, key_press, key_release} !== 3'b000) begin
                errors++;
                $display("FAIL pulse_reset_after cyc%0d outputs=%b expected 000", i,
                         {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_auto_repeat();
        idle_released(2);
        key_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (key_press !== 1'b1) begin
            errors++;
            $display("FAIL repeat_accept prs=%b expected 1", key_press);
        end
        for (int j = 1; j <= 20; j++) begin
            logic exp_press;
            step();
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            exp_press = (j == 10) || (j == 13) || (j == 16) || (j == 19);
`else
            exp_press = 1'b0;
`endif
            checks++;
            if (key_press !== exp_press) begin
                errors++;
                $display("FAIL repeat_hold offset%0d prs=%b expected %b", j, key_press, exp_press);
            end
        end
        key_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (key_press !== 1'b0 || key_release !== (i == 4)) begin
                errors++;
                $display("FAIL repeat_release cyc%0d prs=%b rel=%b expected 0 %b", i,
                         key_press, key_release, (i == 4));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key_in = 1'b1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_reset_mid();
        test_pulse_reset();
        test_auto_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
